// File: rtl/alu_pkg.sv
// Shared ALU/condition types for the execute stage and the branch unit.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
        OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
        OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
        OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
        COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
        COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
        COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Compare-class ops always write flags and never write Rd.
    function automatic logic is_compare(input alu_op_t op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/alu_flags_stage_cond_check.sv
// Combinational ARM condition-field evaluation against an NZCV value.
module cond_check
    import alu_pkg::*;
(
    input  cond_t  cond_i,
    input  flags_t flags_i,
    output logic   pass_o
);

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = flags_i.z;
            COND_NE: pass_o = !flags_i.z;
            COND_CS: pass_o = flags_i.c;
            COND_CC: pass_o = !flags_i.c;
            COND_MI: pass_o = flags_i.n;
            COND_PL: pass_o = !flags_i.n;
            COND_VS: pass_o = flags_i.v;
            COND_VC: pass_o = !flags_i.v;
            COND_HI: pass_o = flags_i.c && !flags_i.z;
            COND_LS: pass_o = !flags_i.c || flags_i.z;
            COND_GE: pass_o = (flags_i.n == flags_i.v);
            COND_LT: pass_o = (flags_i.n != flags_i.v);
            COND_GT: pass_o = !flags_i.z && (flags_i.n == flags_i.v);
            COND_LE: pass_o = flags_i.z || (flags_i.n != flags_i.v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_stage.sv
// Execute stage: ARM data-processing ALU, NZCV register and one-entry output register.
// Optional ALU_SQUASH_CNT_EN adds a 32-bit count of condition-failed accepts.
module alu_flags_stage
    import alu_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rn,
    input  logic [WIDTH-1:0] op2,
    input  logic             shift_c,
    input  logic [3:0]       alu_op,
    input  logic             s_bit,
    input  logic [3:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             rd_we,
    output logic [3:0]       flags
`ifdef ALU_SQUASH_CNT_EN
    ,
    output logic [31:0]      squash_cnt
`endif
);

    alu_op_t          op_e;
    logic             accept;
    logic             pass;

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rd_we_q, rd_we_d;
    flags_t           flags_q, flags_d;

    logic [WIDTH-1:0] a_op, b_op, logic_res, op_res;
    logic             cin, arith, carry, ovf;
    logic [WIDTH:0]   sum;

    assign op_e     = alu_op_t'(alu_op);
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    cond_check u_cond_check (
        .cond_i  (cond_t'(cond)),
        .flags_i (flags_q),
        .pass_o  (pass)
    );

    // Subtraction is a + ~b + cin so carry-out is directly NOT borrow.
    always_comb begin
        a_op      = rn;
        b_op      = op2;
        cin       = 1'b0;
        arith     = 1'b1;
        logic_res = '0;
        case (op_e)
            OP_AND, OP_TST: begin arith = 1'b0; logic_res = rn & op2;  end
            OP_EOR, OP_TEQ: begin arith = 1'b0; logic_res = rn ^ op2;  end
            OP_SUB, OP_CMP: begin b_op = ~op2; cin = 1'b1; end
            OP_RSB:         begin a_op = op2; b_op = ~rn; cin = 1'b1; end
            OP_ADD, OP_CMN: ;
            OP_ADC:         cin = flags_q.c;
            OP_SBC:         begin b_op = ~op2; cin = flags_q.c; end
            OP_RSC:         begin a_op = op2; b_op = ~rn; cin = flags_q.c; end
            OP_ORR:         begin arith = 1'b0; logic_res = rn | op2;  end
            OP_MOV:         begin arith = 1'b0; logic_res = op2;       end
            OP_BIC:         begin arith = 1'b0; logic_res = rn & ~op2; end
            OP_MVN:         begin arith = 1'b0; logic_res = ~op2;      end
            default: ;
        endcase
    end

    assign sum    = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    assign op_res = arith ? sum[WIDTH-1:0] : logic_res;
    assign carry  = arith ? sum[WIDTH] : shift_c;
    assign ovf    = arith ? ((a_op[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]))
                          : flags_q.v;

    always_comb begin
        result_d = pass ? op_res : '0;
        rd_we_d  = pass && !is_compare(op_e);
        flags_d  = flags_q;
        if (pass && (s_bit || is_compare(op_e))) begin
            flags_d.n = op_res[WIDTH-1];
            flags_d.z = (op_res == '0);
            flags_d.c = carry;
            flags_d.v = ovf;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            rd_we_q     <= 1'b0;
            flags_q     <= flags_t'(FLAGS_RESET);
        end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= result_d;
            rd_we_q     <= rd_we_d;
            flags_q     <= flags_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd_we     = rd_we_q;
    assign flags     = flags_q;

`ifdef ALU_SQUASH_CNT_EN
    logic [31:0] squash_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            squash_q <= '0;
        end else if (accept && !pass) begin
            squash_q <= squash_q + 32'd1;
        end
    end

    assign squash_cnt = squash_q;
`endif

endmodule

// File: tb/tb_alu_flags_stage.sv
// Directed-vector bench for alu_flags_stage with hand-computed expectations.
module tb_alu_flags_stage;

    localparam logic [3:0] AND_ = 4'd0,  EOR_ = 4'd1,  SUB_ = 4'd2,  RSB_ = 4'd3;
    localparam logic [3:0] ADD_ = 4'd4,  ADC_ = 4'd5,  SBC_ = 4'd6,  TEQ_ = 4'd9;
    localparam logic [3:0] CMP_ = 4'd10, CMN_ = 4'd11, MOV_ = 4'd13, BIC_ = 4'd14;
    localparam logic [3:0] MVN_ = 4'd15;
    localparam logic [3:0] EQ = 4'd0, MI = 4'd4, HI = 4'd8, LS = 4'd9, GE = 4'd10;
    localparam logic [3:0] AL = 4'd14, NV = 4'd15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] rn, op2;
    logic        shift_c, s_bit;
    logic [3:0]  alu_op, cond;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        rd_we;
    logic [3:0]  flags;
`ifdef ALU_SQUASH_CNT_EN
    logic [31:0] squash_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    alu_flags_stage #(.WIDTH(32), .FLAGS_RESET(4'b0000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rn        (rn),
        .op2       (op2),
        .shift_c   (shift_c),
        .alu_op    (alu_op),
        .s_bit     (s_bit),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_we     (rd_we),
        .flags     (flags)
`ifdef ALU_SQUASH_CNT_EN
        ,
        .squash_cnt(squash_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sc, input logic s, input logic [3:0] c);
        alu_op   = op;
        rn       = a;
        op2      = b;
        shift_c  = sc;
        s_bit    = s;
        cond     = c;
        in_valid = 1'b1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] r, input logic we,
                              input logic [3:0] f);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".result"}, result, r);
        check({tag, ".rd_we"}, {31'd0, rd_we}, {31'd0, we});
        check({tag, ".flags"}, {28'd0, flags}, {28'd0, f});
    endtask

    // Issue one op, take the accepting edge, then compare the registered output.
    task automatic op_vec(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic sc, input logic s,
                          input logic [3:0] c, input logic [31:0] r, input logic we,
                          input logic [3:0] f);
        drive(op, a, b, sc, s, c);
        step();
        expect_out(tag, r, we, f);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(MOV_, 32'd0, 32'd0, 1'b0, 1'b0, AL);
        in_valid  = 1'b0;
        #12;
        check("rst.valid",  {31'd0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.rd_we",  {31'd0, rd_we}, 32'd0);
        check("rst.flags",  {28'd0, flags}, 32'd0);
        check("rst.ready",  {31'd0, in_ready}, 32'd1);
`ifdef ALU_SQUASH_CNT_EN
        check("rst.squash", squash_cnt, 32'd0);
`endif
        reset_n = 1'b1;
        step();

        //      tag      op    rn            op2           sc    s     cond  result        we    NZCV
        op_vec("adds",  ADD_, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b1, AL,   32'h80000000, 1'b1, 4'b1001);
        op_vec("subs",  SUB_, 32'd5,        32'd5,        1'b0, 1'b1, AL,   32'h0,        1'b1, 4'b0110);
        op_vec("moveq", MOV_, 32'd0,        32'h12,       1'b0, 1'b0, EQ,   32'h12,       1'b1, 4'b0110);
        op_vec("cmp",   CMP_, 32'd3,        32'd4,        1'b0, 1'b0, AL,   32'hFFFFFFFF, 1'b0, 4'b1000);
        op_vec("addge", ADD_, 32'd1,        32'd1,        1'b0, 1'b1, GE,   32'h0,        1'b0, 4'b1000);
        op_vec("adds2", ADD_, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b1, AL,   32'h80000000, 1'b1, 4'b1001);
        op_vec("ands",  AND_, 32'hF0,       32'h0F,       1'b1, 1'b1, AL,   32'h0,        1'b1, 4'b0111);
        op_vec("adcs",  ADC_, 32'd1,        32'd2,        1'b0, 1'b1, AL,   32'd4,        1'b1, 4'b0000);
        op_vec("sbcs",  SBC_, 32'd5,        32'd2,        1'b0, 1'b1, AL,   32'd2,        1'b1, 4'b0010);
        op_vec("rsbs",  RSB_, 32'd3,        32'd10,       1'b0, 1'b1, AL,   32'd7,        1'b1, 4'b0010);
        op_vec("movnv", MOV_, 32'd0,        32'h55,       1'b0, 1'b1, NV,   32'h0,        1'b0, 4'b0010);
        op_vec("cmn",   CMN_, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0, AL,   32'h0,        1'b0, 4'b0110);
        op_vec("movhi", MOV_, 32'd0,        32'd7,        1'b0, 1'b0, HI,   32'h0,        1'b0, 4'b0110);
        op_vec("movls", MOV_, 32'd0,        32'd7,        1'b0, 1'b0, LS,   32'd7,        1'b1, 4'b0110);
        op_vec("mvns",  MVN_, 32'd0,        32'h0,        1'b0, 1'b1, AL,   32'hFFFFFFFF, 1'b1, 4'b1000);
        op_vec("eorsmi",EOR_, 32'hFF,       32'h0F,       1'b1, 1'b1, MI,   32'hF0,       1'b1, 4'b0010);
        op_vec("bic",   BIC_, 32'hFF,       32'h0F,       1'b0, 1'b0, AL,   32'hF0,       1'b1, 4'b0010);
        op_vec("teq",   TEQ_, 32'hAA,       32'hAA,       1'b0, 1'b0, AL,   32'h0,        1'b0, 4'b0100);

        in_valid = 1'b0;
        step();
        check("drain.valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: the held slot must not move while writeback stalls.
        op_vec("pre_stall", ADD_, 32'd10, 32'd20, 1'b0, 1'b0, AL, 32'd30, 1'b1, 4'b0100);
        out_ready = 1'b0;
        drive(SUB_, 32'd100, 32'd1, 1'b0, 1'b1, AL);
        #1;
        check("stall.ready0", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall", 32'd30, 1'b1, 4'b0100);
            check("stall.ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release.ready", {31'd0, in_ready}, 32'd1);
        step();
        expect_out("release", 32'd99, 1'b1, 4'b0010);

        // Reset while a result is held under backpressure.
        op_vec("pre_rst", ADD_, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, AL, 32'h80000000, 1'b1, 4'b1001);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        check("held.valid", {31'd0, out_valid}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst.valid",  {31'd0, out_valid}, 32'd0);
        check("midrst.flags",  {28'd0, flags}, 32'd0);
        check("midrst.result", result, 32'd0);
        check("midrst.rd_we",  {31'd0, rd_we}, 32'd0);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();

`ifdef ALU_SQUASH_CNT_EN
        check("sq.after_rst", squash_cnt, 32'd0);
        op_vec("sq_nv1", MOV_, 32'd0, 32'd1, 1'b0, 1'b1, NV, 32'h0, 1'b0, 4'b0000);
        op_vec("sq_nv2", MOV_, 32'd0, 32'd2, 1'b0, 1'b1, NV, 32'h0, 1'b0, 4'b0000);
        check("sq.count", squash_cnt, 32'd2);
        op_vec("sq_al",  MOV_, 32'd0, 32'd3, 1'b0, 1'b0, AL, 32'd3, 1'b1, 4'b0000);
        check("sq.hold", squash_cnt, 32'd2);
`endif

        in_valid = 1'b0;
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_flags_stage.md
Name: alu_flags_stage

Overview:
- Execute-stage consumer of the barrel shifter output (operand2 y, shifter carry c).
- Performs the ARM data-processing ALU operation on Rn and operand2 and evaluates the instruction condition field.
- Holds the architectural NZCV flags register and presents the registered result to writeback over a valid/ready handshake.
- One-entry pipeline register between the shifter and the writeback stage.

Parameters:
- WIDTH, 32, datapath width of operands and result
- FLAGS_RESET, 4'b0000, reset value of the NZCV register

Ports:
- clk  input  1  single clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has an operation
- in_ready  output  1  stage can accept this cycle
- rn  input  WIDTH  first operand
- op2  input  WIDTH  shifter result y
- shift_c  input  1  shifter carry c
- alu_op  input  4  ARM data-processing opcode (AND..MVN)
- s_bit  input  1  set-flags request
- cond  input  4  ARM condition field
- out_valid  output  1  registered result is valid
- out_ready  input  1  writeback accepts the result
- result  output  WIDTH  registered ALU result
- rd_we  output  1  registered: result must be written to Rd
- flags  output  4  NZCV register {N,Z,C,V}

Behaviour:
- Reset (async assert, sync release): out_valid=0, result=0, rd_we=0, flags=FLAGS_RESET.
- in_ready = !out_valid || out_ready, combinational; no combinational path from in_valid to in_ready.
- Accept = in_valid && in_ready. On accept, the output register loads on the next rising edge (latency 1).
- On accept: out_valid=1. Otherwise, if out_ready, out_valid=0. Otherwise everything holds. result, rd_we and out_valid never change while out_valid && !out_ready.
- Condition check uses the flags register value at the accept cycle, i.e. flags already updated by the previous accepted op (back-to-back dependency with no bubble).
- Condition failed:
  - out_valid is still 1, so writeback sees the retired slot.
  - rd_we=0, result=0, flags unchanged.
- Condition passed:
  - rd_we=0 for TST/TEQ/CMP/CMN; 1 otherwise.
  - result = op output for every opcode, including TST..CMN.
- Arithmetic is done at WIDTH+1 bits:
  - SUB/CMP: C = NOT borrow.
  - RSB swaps operands.
  - ADC/SBC/RSC consume the current flags C.
  - V = signed overflow.
- Logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): C = shift_c, V unchanged.
- Flags update on accept only when the condition passed and (s_bit or alu_op is TST/TEQ/CMP/CMN). N = result[WIDTH-1]; Z = (result==0).
- cond=4'b1111 (NV) is treated as never-pass.
- cond=AL passes regardless of flags.
- Reset mid-stall drops the held result; flags return to FLAGS_RESET.

Optional Feature:
- Macro ALU_SQUASH_CNT_EN.
- When defined:
  - Extra output squash_cnt (32 bits, reset 0) increments on every accept whose condition failed.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds during stalls.
- When undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_t (AND=0..MVN=15)
  - typedef enum logic [3:0] cond_t (EQ=0..AL=14, NV=15)
  - typedef struct packed flags_t {n,z,c,v}
  - function is_compare(alu_op_t)
- Sub-module cond_check: combinational (cond, flags) -> pass. It is shared later by the branch unit.

Test Plan:
- ADDS rn=0x7FFFFFFF, op2=1, cond=AL, s=1 -> result=0x80000000 next cycle, rd_we=1, flags N=1 Z=0 C=0 V=1.
- SUBS rn=5, op2=5, then MOVEQ op2=0x12 back-to-back -> first: Z=1 C=1. Second accepted the next cycle: passes, result=0x12, rd_we=1.
- CMP rn=3, op2=4, then ADDGE -> flags N=1 C=0. ADDGE fails: out_valid=1, rd_we=0, result=0, flags unchanged.
- ANDS with shift_c=1, result 0 -> flags Z=1 C=1, V retained from before.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stable. Release -> next op accepted in the same cycle out_ready rises.
- Assert reset_n=0 mid-stall -> out_valid=0 and flags=FLAGS_RESET immediately. With ALU_SQUASH_CNT_EN, 2 failed ops after reset -> squash_cnt=2.
